// File: rtl/cache_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single cache port; req->ack is 2 cycles plus one per stall cycle.
// Stall holds the command; after TIMEOUT stalled cycles the access aborts (read data 0) and sets the sticky err flag.
module cache_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 10,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               we0,
  input  logic [ADDRESS-1:0] addr0,
  input  logic [WIDTH-1:0]   wdata0,
  output logic               ack0,
  output logic [WIDTH-1:0]   rdata0,
  input  logic               req1,
  input  logic               we1,
  input  logic [ADDRESS-1:0] addr1,
  input  logic [WIDTH-1:0]   wdata1,
  output logic               ack1,
  output logic [WIDTH-1:0]   rdata1,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDRESS-1:0] addr,
  output logic [WIDTH-1:0]   data_in,
  input  logic               stall,
  input  logic [WIDTH-1:0]   data_out,
  output logic               err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam logic [15:0] TO  = 16'(TIMEOUT);

  logic [1:0]         state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               gnt_q, gnt_d;
  logic               we_q, we_d;
  logic [ADDRESS-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]   rdata0_q, rdata0_d;
  logic [WIDTH-1:0]   rdata1_q, rdata1_d;
  logic               err_q, err_d;
  logic               sel;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err_d    = err_q;
    sel      = (req0 && req1) ? ptr_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = BUSY;
          gnt_d   = sel;
          we_d    = sel ? we1 : we0;
          addr_d  = sel ? addr1 : addr0;
          wdata_d = sel ? wdata1 : wdata0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // Completion and timeout abort share one exit; stall still high here means abort.
        if (!stall || cnt_q == TO) begin
          state_d = ACK;
          ptr_d   = ~gnt_q;
          err_d   = err_q | stall;
          if (!we_q) begin
            if (gnt_q) rdata1_d = stall ? '0 : data_out;
            else       rdata0_d = stall ? '0 : data_out;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
    end
  end

  assign mem_read  = (state_q == BUSY) && !we_q;
  assign mem_write = (state_q == BUSY) && we_q;
  assign addr      = addr_q;
  assign data_in   = wdata_q;
  assign ack0      = (state_q == ACK) && !gnt_q;
  assign ack1      = (state_q == ACK) && gnt_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed scenarios then random accesses against a transaction-level model.
module tb_cache_port_arbiter;
  localparam int WIDTH   = 32;
  localparam int ADDRESS = 10;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               req0, we0, req1, we1;
  logic [ADDRESS-1:0] addr0, addr1;
  logic [WIDTH-1:0]   wdata0, wdata1;
  logic               ack0, ack1;
  logic [WIDTH-1:0]   rdata0, rdata1;
  logic               mem_read, mem_write;
  logic [ADDRESS-1:0] addr;
  logic [WIDTH-1:0]   data_in;
  logic               stall;
  logic [WIDTH-1:0]   data_out;
  logic               err;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model state
  logic             m_ptr;
  logic [WIDTH-1:0] m_rdata [2];
  logic             m_err;

  always #5 clk = ~clk;

  cache_port_arbiter #(.WIDTH(WIDTH), .ADDRESS(ADDRESS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .data_in(data_in),
    .stall(stall), .data_out(data_out), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 1'b0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    m_err = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_read"},  32'(mem_read),  32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_addr"},      32'(addr),      32'd0);
    chk({tag, "_data_in"},   data_in,        32'd0);
    chk({tag, "_ack0"},      32'(ack0),      32'd0);
    chk({tag, "_ack1"},      32'(ack1),      32'd0);
    chk({tag, "_rdata0"},    rdata0,         32'd0);
    chk({tag, "_rdata1"},    rdata1,         32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
  endtask

  // Called at a negedge while the DUT is IDLE; returns at the negedge of the gap IDLE cycle.
  // nstall = consecutive stall cycles the cache presents; hold keeps requester inputs steady.
  task automatic access(input logic r0, input logic r1, input logic w0, input logic w1,
                        input logic [ADDRESS-1:0] a0, input logic [ADDRESS-1:0] a1,
                        input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                        input int nstall, input logic [WIDTH-1:0] rd, input logic hold,
                        output logic obs_win);
    logic               win, wwe, abort;
    logic [ADDRESS-1:0] wa;
    logic [WIDTH-1:0]   wd;
    int                 nbusy;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    win   = (r0 && r1) ? m_ptr : r1;
    wwe   = win ? w1 : w0;
    wa    = win ? a1 : a0;
    wd    = win ? d1 : d0;
    abort = nstall > TIMEOUT;
    nbusy = abort ? TIMEOUT + 1 : nstall + 1;
    @(posedge clk);
    for (int i = 0; i < nbusy; i++) begin
      @(negedge clk);
      chk("busy_mem_read",  32'(mem_read),  32'(!wwe));
      chk("busy_mem_write", 32'(mem_write), 32'(wwe));
      chk("busy_addr",      32'(addr),      32'(wa));
      chk("busy_data_in",   data_in,        wd);
      chk("busy_ack",       32'({ack1, ack0}), 32'd0);
      stall    = (i < nstall);
      data_out = stall ? $urandom : rd;
      if (!hold) begin
        req0 = 1'b0; req1 = 1'b0;
        we0 = 1'($urandom); we1 = 1'($urandom);
        addr0 = ADDRESS'($urandom); addr1 = ADDRESS'($urandom);
        wdata0 = $urandom; wdata1 = $urandom;
      end
    end
    @(negedge clk);
    if (!wwe) m_rdata[win] = abort ? '0 : rd;
    if (abort) m_err = 1'b1;
    m_ptr   = !win;
    obs_win = ack1;
    chk("ack_ack0",      32'(ack0),      32'(!win));
    chk("ack_ack1",      32'(ack1),      32'(win));
    chk("ack_mem_cmds",  32'({mem_read, mem_write}), 32'd0);
    chk("ack_rdata0",    rdata0,         m_rdata[0]);
    chk("ack_rdata1",    rdata1,         m_rdata[1]);
    chk("ack_err",       32'(err),       32'(m_err));
    stall    = 1'b0;
    data_out = $urandom;
    @(negedge clk);
    chk("gap_ack",       32'({ack1, ack0}), 32'd0);
    chk("gap_mem_cmds",  32'({mem_read, mem_write}), 32'd0);
    chk("gap_rdata0",    rdata0,         m_rdata[0]);
    chk("gap_rdata1",    rdata1,         m_rdata[1]);
  endtask

  initial begin
    logic             w;
    logic             r0, r1;
    int               ns;
    logic [3:0]       order;
    rst = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    stall = 1'b0; data_out = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    // Contention from reset: both reads held, grants must alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      access(1, 1, 0, 0, 10'h011, 10'h022, 32'h0, 32'h0, 0, $urandom, 1, w);
      order[k] = w;
    end
    chk("contention_order", 32'(order), 32'b1010);
    req0 = 0; req1 = 0;

    // Single read
    access(1, 0, 0, 0, 10'h005, 10'h000, 32'h0, 32'h0, 0, 32'hDEADBEEF, 1, w);
    chk("single_read_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 0;

    // Stalled write, five stall cycles
    access(0, 1, 0, 1, 10'h000, 10'h3FF, 32'h0, 32'h12345678, 5, $urandom, 1, w);
    chk("stalled_write_win", 32'(w), 32'd1);
    req1 = 0;

    // Input change/drop after grant, then exactly TIMEOUT stalls (no abort)
    access(1, 0, 0, 0, 10'h0AA, 10'h000, 32'h0, 32'h0, 2, 32'hCAFEF00D, 0, w);
    access(0, 1, 1, 0, 10'h000, 10'h155, 32'h0, 32'h0, TIMEOUT, 32'h0BADBEEF, 0, w);
    chk("no_abort_err", 32'(err), 32'd0);

    // Timeout abort on a read, then a normal access with err still set
    access(0, 1, 1, 0, 10'h000, 10'h077, 32'h0, 32'h0, TIMEOUT + 10, 32'h55555555, 0, w);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_rdata1", rdata1, 32'd0);
    access(1, 0, 0, 0, 10'h0F0, 10'h000, 32'h0, 32'h0, 1, 32'hA5A5A5A5, 0, w);
    chk("post_timeout_err", 32'(err), 32'd1);
    chk("post_timeout_rdata0", rdata0, 32'hA5A5A5A5);

    // Reset mid-access: ptr is 1 here, reset must bring it back to 0
    req0 = 1; we0 = 0; addr0 = 10'h007; req1 = 0; stall = 1;
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy", 32'(mem_read), 32'd1);
    rst = 1'b0; req0 = 0;
    @(negedge clk);
    model_reset();
    chk_reset_outputs("mid_reset");
    stall = 0;
    @(negedge clk);
    chk("mid_reset_ack", 32'({ack1, ack0}), 32'd0);
    rst = 1'b1;
    access(1, 1, 0, 0, 10'h001, 10'h002, 32'h0, 32'h0, 0, 32'h11111111, 0, w);
    chk("post_reset_ptr_win", 32'(w), 32'd0);
    access(0, 1, 0, 0, 10'h000, 10'h003, 32'h0, 32'h0, 0, 32'h22222222, 0, w);
    chk("post_reset_req1_win", 32'(w), 32'd1);

    // Random accesses
    for (int k = 0; k < 40; k++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      ns = ($urandom_range(0, 15) == 0) ? TIMEOUT + 1 + $urandom_range(0, 3)
                                        : $urandom_range(0, 3);
      access(r0, r1, 1'($urandom), 1'($urandom), ADDRESS'($urandom), ADDRESS'($urandom),
             $urandom, $urandom, ns, $urandom, 1'($urandom), w);
    end
    req0 = 0; req1 = 0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, data width; ADDRESS, 10, address width; TIMEOUT, 64, max stall cycles per access before abort.
REQ-002 Ports SHALL be (clock and reset first):
 clk  in  1  single clock, all logic on rising edge
 rst  in  1  synchronous, active-low reset (sampled on clk)
 req0  in  1  requester 0 access request, level, held until ack0
 we0  in  1  requester 0: 1=write, 0=read
 addr0  in  ADDRESS  requester 0 address
 wdata0  in  WIDTH  requester 0 write data
 ack0  out  1  requester 0 completion pulse
 rdata0  out  WIDTH  requester 0 read data, valid with ack0 and held after
 req1/we1/addr1/wdata1/ack1/rdata1  same as requester 0, for requester 1
 mem_read  out  1  cache read command
 mem_write  out  1  cache write command
 addr  out  ADDRESS  cache address
 data_in  out  WIDTH  cache write data
 stall  in  1  cache busy (miss fill or write-through in progress)
 data_out  in  WIDTH  cache read data
 err  out  1  sticky timeout flag

Function
REQ-003 FSM SHALL have states IDLE, BUSY, ACK.
REQ-004 IDLE: no req -> stay; any req -> latch winner's we/addr/wdata and winner id, go BUSY next cycle.
REQ-005 Arbitration SHALL be round-robin via 1-bit pointer ptr: both requesting -> grant requester ptr; one requesting -> grant it regardless of ptr.
REQ-006 ptr SHALL be set to the opposite of the serviced requester when entering ACK; unchanged otherwise.
REQ-007 BUSY: mem_write = latched we, mem_read = not latched we, addr/data_in = latched values, held constant for the whole state.
REQ-008 mem_read and mem_write SHALL never be asserted together, and SHALL be 0 outside BUSY.
REQ-009 BUSY with stall=0 -> capture data_out into granted rdataN (reads only; writes leave rdataN unchanged), go ACK.
REQ-010 BUSY with stall=1 -> increment 16-bit-wide-enough stall counter, stay BUSY.
REQ-011 Stall counter SHALL clear on entry to BUSY; when it reaches TIMEOUT with stall still 1 -> set err, capture 0 into rdataN for reads, go ACK (abort).
REQ-012 ACK: ackN=1 for exactly one cycle for the granted requester only, commands deasserted, next state IDLE.
REQ-013 Minimum latency: req sampled in IDLE at cycle t -> BUSY t+1 -> ackN at t+2 when stall=0 at t+1; each stall cycle adds one.
REQ-014 The IDLE cycle after ACK SHALL be a mandatory gap; a requester whose req is still high then is treated as a new request.
REQ-015 Requester inputs changing or req dropping after grant SHALL NOT affect the in-flight access (latched values used, ack still issued).
REQ-016 err SHALL stay 1 until reset; it SHALL NOT block further accesses.
REQ-017 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-018 rst=0 at a rising edge SHALL force: state IDLE, ptr=0, mem_read=0, mem_write=0, addr=0, data_in=0, ack0=ack1=0, rdata0=rdata1=0, err=0, stall counter=0.
REQ-019 Reset during BUSY or ACK SHALL abort the access with no ack issued; first post-reset grant follows REQ-005 with ptr=0.

Verification
REQ-020 Single read: req0=1, we0=0, addr0=0x05, stall=0, data_out=0xDEADBEEF -> mem_read=1 addr=0x05 one cycle after req, ack0 pulse next cycle, rdata0=0xDEADBEEF.
REQ-021 Contention: req0=req1=1 from reset, both reads, held -> grant order 0,1,0,1 with ack pulses alternating, one gap IDLE cycle between accesses.
REQ-022 Stalled write: req1=1, we1=1, addr1=0x3FF, wdata1=0x12345678, stall=1 for 5 cycles -> mem_write=1 held 6 cycles with constant addr/data_in, ack1 one cycle after stall falls, rdata1 unchanged.
REQ-023 Timeout: read with stall held 1 indefinitely, TIMEOUT=64 -> after 64 stall cycles err=1, ack pulse, rdata=0; next access completes normally with err still 1.
REQ-024 Reset mid-access: assert rst=0 while in BUSY -> next cycle all outputs at reset values, no ack; after release with req1 only, grant to 1.
REQ-025 Input change after grant: change addr0 and drop req0 during BUSY -> addr output keeps original latched value, ack0 still pulses once.
